mux3_rr_arbiter: RTL and testbench
==================================

# mux3_rr_arbiter

Round-robin arbiter and select sequencer for the shared 3-input 32-bit operand/result mux in the Extended DLX datapath. It shares the mux between three requesters: port 0 is the DLX core, port 1 is the TinyML accelerator, and port 2 is the DMA/load path. It grants one requester at a time, holds the grant for a whole multi-cycle transfer, and enforces a bounded hold time. It drives the mux `sel` directly, plus a one-hot grant back to the requesters.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive cycles one requester may hold the grant (range 2–255).
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  3  level request per port; held high for the whole transfer.
- `gnt`  out  3  registered one-hot grant; all zeros when idle.
- `sel`  out  2  registered mux select: 00 = port0 (A), 01 = port1 (B), 10 = port2 (C), 11 = none (mux outputs 0).
- `busy`  out  1  high while any grant is active.
- `timeout`  out  1  one-cycle pulse when a grant is force-released at `MAX_HOLD`.
- `hold_cnt`  out  8  current grant age in cycles (debug/perf).

## Operation
- States: IDLE, HOLD, COOL.
- **IDLE**
  - If `req` is nonzero, pick the winner from the rotating priority pointer `ptr` (0..2).
  - Search order is `ptr`, `ptr+1`, `ptr+2`, each mod 3.
  - Load `gnt`/`sel` for the winner and clear `hold_cnt` to 1.
  - Go to HOLD.
  - If `req` is zero, stay in IDLE.
- **HOLD**
  - While `req[winner]` is 1 and `hold_cnt < MAX_HOLD`: stay, and `hold_cnt` increments by 1 per cycle.
  - If `req[winner]` is 0: release (`gnt`=0, `sel`=11), set `ptr` = winner+1 mod 3, go to COOL.
  - If `hold_cnt == MAX_HOLD` and `req[winner]` is still 1: force the same release, pulse `timeout`, go to COOL.
- **COOL**
  - Exactly one dead-bus cycle with `sel`=11.
  - Then go to IDLE, which arbitrates the same cycle it is entered.
- **Fairness**
  - A timed-out requester that keeps `req` high has lowest priority in the next arbitration.
  - Any requester waits at most 2 × (`MAX_HOLD` + 2) cycles for a grant.
- Requests from non-granted ports change nothing during HOLD or COOL.
- `gnt` is always one-hot or zero. `sel`=11 exactly when `gnt`=0.
- `hold_cnt` wraps are impossible by construction; it saturates at `MAX_HOLD`.
- **Reset**
  - Values: `gnt`=000, `sel`=11, `busy`=0, `timeout`=0, `hold_cnt`=0, `ptr`=0, state IDLE.
  - Reset mid-HOLD drops the grant on the next edge. No COOL cycle and no `timeout` pulse.

## Timing
- **Grant latency:** `req` sampled high in IDLE at edge t gives `gnt`/`sel` valid after edge t+1.
- **Release latency:** `req[winner]` sampled low at edge t gives `gnt`=0 after t+1. The earliest next grant is after t+3 (COOL, then IDLE arbitration).
- **Timeout:** the grant lasts exactly `MAX_HOLD` cycles. `timeout` is high for the single cycle where `gnt` first reads 0.
- **Simultaneous events in HOLD:** `req` drop and `hold_cnt == MAX_HOLD` on the same edge count as a normal release, with no `timeout`.
- **Simultaneous requests in IDLE:** resolved purely by `ptr`. No requester has fixed priority after the first grant.

## Structure
- Package `dlx_arb_pkg` holds:
  - the state enum (`ARB_IDLE`, `ARB_HOLD`, `ARB_COOL`);
  - select constants `SEL_A`=00, `SEL_B`=01, `SEL_C`=10, `SEL_NONE`=11;
  - the port index constants.
- The package is shared with the mux instantiation site.
- One combinational sub-module, `rr_pick3`:
  - inputs: `req[2:0]`, `ptr[1:0]`;
  - outputs: `win_valid`, `win_idx[1:0]`.
- The FSM, counter and output registers live in the top.

## Test plan
- **Reset/idle:** after `rst`, `req`=000 for 10 cycles → `gnt`=000, `sel`=11, `busy`=0 throughout.
- **Single transfer:** `req`=010 for 5 cycles → `gnt`=010 and `sel`=01 for 5 cycles, starting one cycle after the request. Then one COOL cycle with `sel`=11. `ptr` becomes 2.
- **Rotation:** `req`=111 held, with each winner dropping `req` after 3 cycles and re-raising 1 cycle later → grant order 0, 1, 2, 0. Each grant is 3 cycles, separated by one COOL and one IDLE cycle.
- **Timeout** (`MAX_HOLD`=4): `req`=001 held forever and `req`=100 raised → port 0 holds 4 cycles, `timeout` pulses, COOL, then port 2 is granted (`sel`=10) ahead of port 0.
- **Drop at limit** (`MAX_HOLD`=4): port 1 drops `req` on the 4th held cycle → release with no `timeout` pulse.
- **Reset mid-HOLD:** `rst` asserted on the 2nd grant cycle of port 2 → next edge `gnt`=000, `sel`=11, `ptr`=0. After `rst` falls with `req`=101, port 0 is granted first.

Source files
------------

// File: rtl/dlx_arb_pkg.sv
// Shared types and constants for the 3-input operand/result mux and its arbiter.
package dlx_arb_pkg;

    localparam int unsigned NUM_PORTS = 3;
    localparam int unsigned IDX_W     = 2;
    localparam int unsigned CNT_W     = 8;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_HOLD = 2'd1,
        ARB_COOL = 2'd2
    } arb_state_t;

    // Mux select encodings; SEL_NONE forces the mux output to zero.
    localparam logic [IDX_W-1:0] SEL_A    = 2'b00;
    localparam logic [IDX_W-1:0] SEL_B    = 2'b01;
    localparam logic [IDX_W-1:0] SEL_C    = 2'b10;
    localparam logic [IDX_W-1:0] SEL_NONE = 2'b11;

    // Requester indices: DLX core, TinyML accelerator, DMA/load path.
    localparam logic [IDX_W-1:0] PORT_CORE = 2'd0;
    localparam logic [IDX_W-1:0] PORT_ML   = 2'd1;
    localparam logic [IDX_W-1:0] PORT_DMA  = 2'd2;

    // Next port in round-robin order (mod 3).
    function automatic logic [IDX_W-1:0] next_port(input logic [IDX_W-1:0] idx);
        case (idx)
            PORT_CORE: next_port = PORT_ML;
            PORT_ML:   next_port = PORT_DMA;
            default:   next_port = PORT_CORE;
        endcase
    endfunction

    // One-hot grant vector for a port index.
    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [IDX_W-1:0] idx);
        case (idx)
            PORT_CORE: port_onehot = 3'b001;
            PORT_ML:   port_onehot = 3'b010;
            PORT_DMA:  port_onehot = 3'b100;
            default:   port_onehot = 3'b000;
        endcase
    endfunction

    // Mux select for a port index.
    function automatic logic [IDX_W-1:0] port_sel(input logic [IDX_W-1:0] idx);
        case (idx)
            PORT_CORE: port_sel = SEL_A;
            PORT_ML:   port_sel = SEL_B;
            PORT_DMA:  port_sel = SEL_C;
            default:   port_sel = SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational 3-way round-robin picker: first requester at or after ptr.
module rr_pick3
    import dlx_arb_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic       win_valid,
    output logic [1:0] win_idx
);

    logic [IDX_W-1:0] cand0;
    logic [IDX_W-1:0] cand1;
    logic [IDX_W-1:0] cand2;

    // Search ptr, ptr+1, ptr+2 (mod 3); an illegal ptr behaves as port 0.
    always_comb begin
        cand0     = (ptr > PORT_DMA) ? PORT_CORE : ptr;
        cand1     = next_port(cand0);
        cand2     = next_port(cand1);
        win_valid = |req;
        win_idx   = cand0;
        if (req[cand0]) begin
            win_idx = cand0;
        end else if (req[cand1]) begin
            win_idx = cand1;
        end else if (req[cand2]) begin
            win_idx = cand2;
        end
    end

endmodule

// File: rtl/mux3_rr_arbiter.sv
// Round-robin arbiter and select sequencer for the shared 3-input 32-bit mux.
// Grants are held for a whole transfer, bounded by MAX_HOLD, and every
// release is followed by one dead-bus cycle before the next arbitration.
module mux3_rr_arbiter
    import dlx_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    output logic [2:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       timeout,
    output logic [7:0] hold_cnt
);

    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);

    arb_state_t           state_q;
    arb_state_t           state_d;
    logic [IDX_W-1:0]     ptr_q;
    logic [IDX_W-1:0]     ptr_d;
    logic [IDX_W-1:0]     win_q;
    logic [IDX_W-1:0]     win_d;
    logic [NUM_PORTS-1:0] gnt_d;
    logic [IDX_W-1:0]     sel_d;
    logic                 busy_d;
    logic                 timeout_d;
    logic [CNT_W-1:0]     hold_d;

    logic                 win_valid;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_req;

    rr_pick3 u_pick (
        .req       (req),
        .ptr       (ptr_q),
        .win_valid (win_valid),
        .win_idx   (win_idx)
    );

    // The current owner's request, via the one-hot grant.
    assign win_req = |(req & gnt);

    // State, pointer and output registers; reset drops any grant immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            ptr_q    <= PORT_CORE;
            win_q    <= PORT_CORE;
            gnt      <= '0;
            sel      <= SEL_NONE;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            hold_cnt <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            gnt      <= gnt_d;
            sel      <= sel_d;
            busy     <= busy_d;
            timeout  <= timeout_d;
            hold_cnt <= hold_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        gnt_d     = gnt;
        sel_d     = sel;
        busy_d    = busy;
        timeout_d = 1'b0;
        hold_d    = hold_cnt;

        case (state_q)
            ARB_IDLE: begin
                if (win_valid) begin
                    state_d = ARB_HOLD;
                    win_d   = win_idx;
                    gnt_d   = port_onehot(win_idx);
                    sel_d   = port_sel(win_idx);
                    busy_d  = 1'b1;
                    hold_d  = CNT_W'(1);
                end
            end

            ARB_HOLD: begin
                if (!win_req || hold_cnt >= HOLD_LIMIT) begin
                    // A drop on the limit cycle is a normal release, not a timeout.
                    state_d   = ARB_COOL;
                    ptr_d     = next_port(win_q);
                    gnt_d     = '0;
                    sel_d     = SEL_NONE;
                    busy_d    = 1'b0;
                    hold_d    = '0;
                    timeout_d = win_req;
                end else begin
                    hold_d = CNT_W'(hold_cnt + CNT_W'(1));
                end
            end

            ARB_COOL: begin
                state_d = ARB_IDLE;
            end

            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
                sel_d   = SEL_NONE;
                busy_d  = 1'b0;
                hold_d  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Vector-table bench for mux3_rr_arbiter with an in-order expectation queue.
// Two instances share stimulus: default MAX_HOLD and MAX_HOLD=4.
module tb_mux3_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;

    logic [2:0] gnt16, gnt4;
    logic [1:0] sel16, sel4;
    logic       busy16, busy4;
    logic       to16, to4;
    logic [7:0] hc16, hc4;

    always #5 clk = ~clk;

    mux3_rr_arbiter u_dut16 (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .gnt      (gnt16),
        .sel      (sel16),
        .busy     (busy16),
        .timeout  (to16),
        .hold_cnt (hc16)
    );

    mux3_rr_arbiter #(.MAX_HOLD(4)) u_dut4 (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .gnt      (gnt4),
        .sel      (sel4),
        .busy     (busy4),
        .timeout  (to4),
        .hold_cnt (hc4)
    );

    typedef struct {
        string      name;
        logic       rst;
        logic [2:0] req;
        logic [2:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       to;
        logic [7:0] hc;
        logic       m4;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   tests = 0;
    int   fails = 0;

    function automatic void add(string n, logic r, logic [2:0] rq, logic [2:0] g,
                                logic [1:0] s, logic b, logic t, logic [7:0] h, logic m);
        vec_t v;
        v.name = n; v.rst = r; v.req = rq; v.gnt = g; v.sel = s;
        v.busy = b; v.to = t; v.hc = h; v.m4 = m;
        vecs.push_back(v);
    endfunction

    // No grant, no timeout pulse.
    function automatic void idle(string n, logic r, logic [2:0] rq, logic m);
        add(n, r, rq, 3'b000, 2'b11, 1'b0, 1'b0, 8'd0, m);
    endfunction

    // Port p owns the mux with grant age h.
    function automatic void granted(string n, logic [2:0] rq, int p, int h, logic m);
        logic [2:0] g;
        g = 3'(3'b001 << p);
        add(n, 1'b0, rq, g, 2'(p), 1'b1, 1'b0, 8'(h), m);
    endfunction

    // Release edge; t says whether it was forced.
    function automatic void rel(string n, logic [2:0] rq, logic t, logic m);
        add(n, 1'b0, rq, 3'b000, 2'b11, 1'b0, t, 8'd0, m);
    endfunction

    task automatic check(string n, string f, logic [7:0] act, logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s.%s: got %0h expected %0h (t=%0t)", n, f, act, exp, $time);
        end
    endtask

    // Pop one expectation per edge and compare just after it.
    always @(posedge clk) begin : mon
        vec_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.m4) begin
                check(e.name, "gnt",      8'(gnt4),  8'(e.gnt));
                check(e.name, "sel",      8'(sel4),  8'(e.sel));
                check(e.name, "busy",     8'(busy4), 8'(e.busy));
                check(e.name, "timeout",  8'(to4),   8'(e.to));
                check(e.name, "hold_cnt", hc4,       e.hc);
            end else begin
                check(e.name, "gnt",      8'(gnt16),  8'(e.gnt));
                check(e.name, "sel",      8'(sel16),  8'(e.sel));
                check(e.name, "busy",     8'(busy16), 8'(e.busy));
                check(e.name, "timeout",  8'(to16),   8'(e.to));
                check(e.name, "hold_cnt", hc16,       e.hc);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [2:0] drop;
        rst = 1'b1;
        req = 3'b000;

        // Reset and idle.
        idle("reset", 1'b1, 3'b000, 1'b0);
        for (int i = 0; i < 10; i++) idle("idle", 1'b0, 3'b000, 1'b0);

        // Single 5-cycle transfer on port 1, then COOL ignores new requests.
        for (int k = 1; k <= 5; k++) granted("single", 3'b010, 1, k, 1'b0);
        rel("single_rel", 3'b000, 1'b0, 1'b0);
        idle("cool_ignore", 1'b0, 3'b111, 1'b0);
        granted("ptr_is_2", 3'b111, 2, 1, 1'b0);
        rel("ptr2_rel", 3'b000, 1'b0, 1'b0);
        idle("ptr2_cool", 1'b0, 3'b000, 1'b0);
        idle("ptr2_idle", 1'b0, 3'b000, 1'b0);

        // Rotation with all ports requesting: order 0,1,2,0.
        for (int r = 0; r < 4; r++) begin
            drop = 3'(3'b111 & ~(3'b001 << (r % 3)));
            for (int k = 1; k <= 3; k++) granted("rot", 3'b111, r % 3, k, 1'b0);
            rel("rot_rel", drop, 1'b0, 1'b0);
            idle("rot_cool", 1'b0, 3'b111, 1'b0);
        end

        // Timeout with MAX_HOLD=4: port 0 hogs, port 2 must win next.
        idle("to_reset", 1'b1, 3'b000, 1'b1);
        granted("to_hold", 3'b001, 0, 1, 1'b1);
        for (int k = 2; k <= 4; k++) granted("to_hold", 3'b101, 0, k, 1'b1);
        rel("to_pulse", 3'b101, 1'b1, 1'b1);
        idle("to_cool", 1'b0, 3'b101, 1'b1);
        granted("to_port2", 3'b101, 2, 1, 1'b1);
        rel("to_port2_rel", 3'b001, 1'b0, 1'b1);
        idle("to_cool2", 1'b0, 3'b001, 1'b1);
        granted("to_port0", 3'b001, 0, 1, 1'b1);
        rel("to_port0_rel", 3'b000, 1'b0, 1'b1);
        idle("to_cool3", 1'b0, 3'b000, 1'b1);

        // Drop exactly at the limit: normal release, no timeout.
        idle("drop_reset", 1'b1, 3'b000, 1'b1);
        for (int k = 1; k <= 4; k++) granted("drop_hold", 3'b010, 1, k, 1'b1);
        rel("drop_rel", 3'b000, 1'b0, 1'b1);
        idle("drop_cool", 1'b0, 3'b000, 1'b1);

        // Reset on port 2's second grant cycle; ptr returns to 0.
        idle("rmh_reset0", 1'b1, 3'b000, 1'b0);
        granted("rmh_p0", 3'b001, 0, 1, 1'b0);
        rel("rmh_p0_rel", 3'b000, 1'b0, 1'b0);
        idle("rmh_cool", 1'b0, 3'b000, 1'b0);
        granted("rmh_p2", 3'b100, 2, 1, 1'b0);
        granted("rmh_p2", 3'b100, 2, 2, 1'b0);
        idle("rmh_reset", 1'b1, 3'b101, 1'b0);
        granted("rmh_after", 3'b101, 0, 1, 1'b0);
        granted("rmh_after", 3'b101, 0, 2, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst;
            req = vecs[i].req;
            sb.push_back(vecs[i]);
        end
        repeat (3) @(negedge clk);

        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
